// File: rtl/stack_arbiter.sv
// stack_arbiter: two-client round-robin arbiter in front of a DEPTH x WIDTH LIFO stack.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req0/1, op0/1         per-client request and operation (0 = push, 1 = pop)
//   wdata0/1              per-client push data
//   gnt0/1, err, rdata    one-cycle completion pulse, reject flag, popped word
//   full, empty, level    occupancy decoded from the count register
module stack_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  op0,
    input  logic                  op1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [WIDTH-1:0]      rdata,
    output logic                  err,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);
    typedef enum logic {IDLE, ACK} state_t;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    state_t state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] count, count_n;
    logic [ADDR_WIDTH-1:0] top;
    logic [WIDTH-1:0] wdata, rdata_n;
    logic last, last_n, win, op, take, is_full, is_empty, we, rd, gnt0_n, gnt1_n, err_n;
    always_comb begin
        // last = 1 means client 1 was granted most recently, so client 0 wins a tie
        win      = (req0 && req1) ? ~last : req1;
        op       = win ? op1 : op0;
        wdata    = win ? wdata1 : wdata0;
        is_full  = count == DEPTH_C;
        is_empty = count == '0;
        top      = ADDR_WIDTH'(count - 1'b1);
        take     = state == IDLE && (req0 || req1);
        state_n  = take ? ACK : IDLE;
        last_n   = take ? win : last;
        gnt0_n   = take && !win;
        gnt1_n   = take && win;
        err_n    = take && (op ? is_empty : is_full);
        we       = take && !op && !is_full;
        rd       = take && op && !is_empty;
        count_n  = we ? count + 1'b1 : rd ? count - 1'b1 : count;
        rdata_n  = rd ? mem[top] : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            last  <= last_n;
            gnt0  <= gnt0_n;
            gnt1  <= gnt1_n;
            err   <= err_n;
            rdata <= rdata_n;
        end
    end
    // storage is not cleared; it becomes unreachable once count returns to 0
    always_ff @(posedge clk) begin
        if (we && !reset) mem[count[ADDR_WIDTH-1:0]] <= wdata;
    end
    // reset forces the idle occupancy view even before count is cleared
    assign full  = !reset && is_full;
    assign empty = reset || is_empty;
    assign level = reset ? '0 : count;
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of stack entries.
REQ-003 Parameter ADDR_WIDTH, default 3, log2(DEPTH).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 req0, req1  input  1 each  per-client operation request; held high until the matching grant.
REQ-007 op0, op1  input  1 each  per-client operation select; 0 = push, 1 = pop; stable while req is high.
REQ-008 wdata0, wdata1  input  WIDTH each  per-client push data; stable while req is high.
REQ-009 gnt0, gnt1  output  1 each  one-cycle completion pulse to the client whose operation executed.
REQ-010 rdata  output  WIDTH  popped word; valid only while gnt0 or gnt1 is high.
REQ-011 err  output  1  high with the grant pulse when the operation was rejected (push on full, pop on empty).
REQ-012 full  output  1  high when the stored count equals DEPTH.
REQ-013 empty  output  1  high when the stored count equals 0.
REQ-014 level  output  ADDR_WIDTH+1  current number of stored entries.

Function
REQ-015 Block SHALL contain DEPTH x WIDTH LIFO storage plus a count register of ADDR_WIDTH+1 bits; count SHALL be the only stack pointer.
REQ-016 FSM SHALL have two states: IDLE and ACK.
REQ-017 IDLE: if no req is high, remain in IDLE; if any req is high, select a winner, execute its operation at that clock edge, and enter ACK.
REQ-018 ACK: the winner's gnt is high for exactly one cycle; no new selection occurs; the FSM returns to IDLE at the next edge. Throughput is therefore one operation per two cycles.
REQ-019 Arbitration SHALL be round-robin via a last-grant register. When both clients request, the client not granted most recently wins; a lone requester always wins.
REQ-020 Latency: a req sampled high in IDLE at edge N SHALL produce gnt high during cycle N+1 (registered output).
REQ-021 Accepted push (count < DEPTH): mem[count] <= wdata, count <= count+1, err = 0, rdata = 0.
REQ-022 Accepted pop (count > 0): rdata <= mem[count-1], count <= count-1, err = 0.
REQ-023 Rejected push (count == DEPTH): storage and count unchanged; err = 1 with gnt.
REQ-024 Rejected pop (count == 0): count unchanged; rdata = 0; err = 1 with gnt.
REQ-025 full, empty and level SHALL be decoded combinationally from count and SHALL reflect the post-operation count in the ACK cycle.
REQ-026 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-027 rdata and err SHALL be 0 whenever neither gnt is high.
REQ-028 A client SHALL drop req in its gnt cycle. A req still high when the FSM is back in IDLE is treated as a new request.

Reset
REQ-029 While reset is high at a clk edge: FSM <= IDLE, count <= 0, last-grant <= client 1 (so client 0 wins the first tie), gnt0 = gnt1 = 0, err = 0, rdata = 0.
REQ-030 While reset is high: full = 0, empty = 1, level = 0.
REQ-031 Reset asserted during ACK SHALL suppress the pending gnt in the following cycle and discard all stored data; reset has priority over every request.
REQ-032 Storage contents need not be cleared by reset; they are unreachable after reset because count = 0.

Verification
REQ-033 After reset, req0 = 1, op0 = 0, wdata0 = 8'hA5 -> gnt0 high one cycle later, err = 0, level = 1, empty = 0.
REQ-034 Both clients request every cycle with push of 8'h11 (client 0) and 8'h22 (client 1) -> grants alternate gnt0, gnt1, gnt0, gnt1, with a single grant cycle each two cycles; after 4 grants level = 4.
REQ-035 Push 8'h01..8'h08, then pop 8 times -> full = 1 after the 8th push; pops return 8'h08 down to 8'h01; empty = 1 at the end.
REQ-036 Ninth push on full -> gnt with err = 1, level stays 8; pop on empty -> gnt with err = 1, rdata = 0, level stays 0.
REQ-037 Reset asserted in the ACK cycle of a push -> no gnt in the next cycle, level = 0, empty = 1; a following tie grants client 0 first.
